// File: rtl/cpu_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arb_pkg
// Description : Shared types and constants for the CPU memory arbiter.
//               Holds the arbiter state encoding and the requester ids that
//               travel on mem_req_id / mem_rsp_id.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_t;

  localparam logic DCACHE_ID = 1'b0;
  localparam logic ICACHE_ID = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arb_grant
// Description : Winner picker plus starvation counter. The dcache wins by
//               default; the icache wins when it is the only requester or
//               when it has watched MAX_WAIT dcache grants go by.
// Ports       : clock, reset (sync, active-low)
//               grant_en  - arbiter is able to accept a request this cycle
//               d_req     - dcache has a request (read or write)
//               i_req     - icache has a request (read or write)
//               grant_d   - dcache granted this cycle
//               grant_i   - icache granted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arb_grant #(
  parameter int MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_en,
  input  logic d_req,
  input  logic i_req,
  output logic grant_d,
  output logic grant_i
);

  localparam int CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] C_MAX_WAIT = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0] r_starve_cnt;
  logic                 w_i_wins;

  assign w_i_wins = i_req & (~d_req | (r_starve_cnt == C_MAX_WAIT));
  assign grant_i  = grant_en & w_i_wins;
  assign grant_d  = grant_en & d_req & ~w_i_wins;

  // Counts dcache grants that happened while the icache was left waiting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (grant_i) begin
      r_starve_cnt <= '0;
    end else if (grant_d && i_req && (r_starve_cnt != C_MAX_WAIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Arbitrates dcache and icache line requests onto a single
//               memory bus with one transaction outstanding, and routes the
//               memory response back to the owning cache.
// Ports       : clock, reset (sync, active-low)
//               d_req_* / i_req_*   cache requests (level, held until ready)
//               d_req_ready/i_req_ready  one-cycle acceptance pulses
//               mem_req_*           registered bus request, mem_req_ready in
//               mem_rsp_*           memory response in
//               d_rsp_* / i_rsp_*   routed, registered responses
//               busy                transaction in flight
//               protocol_error      sticky protocol violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_req_read,
  input  logic                  d_req_write,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [LINE_WIDTH-1:0] d_req_data,
  input  logic                  i_req_read,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LINE_WIDTH-1:0] i_req_data,
  output logic                  d_req_ready,
  output logic                  i_req_ready,
  output logic                  mem_req_read,
  output logic                  mem_req_write,
  output logic                  mem_req_id,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic                  mem_rsp_id,
  input  logic [ADDR_WIDTH-1:0] mem_rsp_addr,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data,
  output logic                  d_rsp_valid,
  output logic [ADDR_WIDTH-1:0] d_rsp_addr,
  output logic [LINE_WIDTH-1:0] d_rsp_data,
  output logic                  i_rsp_valid,
  output logic [ADDR_WIDTH-1:0] i_rsp_addr,
  output logic [LINE_WIDTH-1:0] i_rsp_data,
  output logic                  busy,
  output logic                  protocol_error
);

  arb_state_t            r_state;
  logic                  w_d_req;
  logic                  w_i_req;
  logic                  w_grant_en;
  logic                  w_grant_d;
  logic                  w_grant_i;
  logic                  w_win_read;
  logic                  w_win_write;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [LINE_WIDTH-1:0] w_win_data;

  assign w_d_req = d_req_read | d_req_write;
  assign w_i_req = i_req_read | i_req_write;

  // Gating with reset keeps the ready pulses quiet while reset is held.
  assign w_grant_en = reset & (r_state == IDLE);

  cpu_mem_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clock    (clock),
    .reset    (reset),
    .grant_en (w_grant_en),
    .d_req    (w_d_req),
    .i_req    (w_i_req),
    .grant_d  (w_grant_d),
    .grant_i  (w_grant_i)
  );

  // Ready is combinational so the requester sees acceptance in the same
  // cycle the arbiter samples its payload.
  assign d_req_ready = w_grant_d;
  assign i_req_ready = w_grant_i;

  assign w_win_read  = w_grant_i ? i_req_read  : d_req_read;
  assign w_win_write = w_grant_i ? i_req_write : d_req_write;
  assign w_win_addr  = w_grant_i ? i_req_addr  : d_req_addr;
  assign w_win_data  = w_grant_i ? i_req_data  : d_req_data;

  assign busy = (r_state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= IDLE;
      mem_req_read   <= 1'b0;
      mem_req_write  <= 1'b0;
      mem_req_id     <= DCACHE_ID;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      d_rsp_valid    <= 1'b0;
      d_rsp_addr     <= '0;
      d_rsp_data     <= '0;
      i_rsp_valid    <= 1'b0;
      i_rsp_addr     <= '0;
      i_rsp_data     <= '0;
      protocol_error <= 1'b0;
    end else begin
      d_rsp_valid <= 1'b0;
      i_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_rsp_valid) begin
            protocol_error <= 1'b1;
          end
          if (w_grant_d || w_grant_i) begin
            // A read+write request is issued as a write and flagged.
            mem_req_write <= w_win_write;
            mem_req_read  <= w_win_read & ~w_win_write;
            mem_req_id    <= w_grant_i ? ICACHE_ID : DCACHE_ID;
            mem_req_addr  <= w_win_addr;
            mem_req_data  <= w_win_data;
            if (w_win_read && w_win_write) begin
              protocol_error <= 1'b1;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rsp_valid) begin
            protocol_error <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_read  <= 1'b0;
            mem_req_write <= 1'b0;
            r_state       <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_id == mem_req_id) begin
              if (mem_req_id == ICACHE_ID) begin
                i_rsp_valid <= 1'b1;
                i_rsp_addr  <= mem_rsp_addr;
                i_rsp_data  <= mem_rsp_data;
              end else begin
                d_rsp_valid <= 1'b1;
                d_rsp_addr  <= mem_rsp_addr;
                d_rsp_data  <= mem_rsp_data;
              end
              r_state <= IDLE;
            end else begin
              protocol_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_arbiter
// Description : Self-checking bench for cpu_mem_arbiter: directed scenarios
//               plus a randomized run against a behavioural model of the
//               arbitration rules and the bus handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          d_req_read, d_req_write, i_req_read, i_req_write;
  logic [AW-1:0] d_req_addr, i_req_addr, mem_req_addr, mem_rsp_addr;
  logic [LW-1:0] d_req_data, i_req_data, mem_req_data, mem_rsp_data;
  logic          d_req_ready, i_req_ready;
  logic          mem_req_read, mem_req_write, mem_req_id, mem_req_ready;
  logic          mem_rsp_valid, mem_rsp_id;
  logic          d_rsp_valid, i_rsp_valid;
  logic [AW-1:0] d_rsp_addr, i_rsp_addr;
  logic [LW-1:0] d_rsp_data, i_rsp_data;
  logic          busy, protocol_error;

  int n_checks = 0;
  int n_errors = 0;
  bit grant_log[$];

  always #5 clock = ~clock;

  cpu_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .d_req_read(d_req_read), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .i_req_read(i_req_read), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .d_req_ready(d_req_ready), .i_req_ready(i_req_ready),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_req_id(mem_req_id), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id),
    .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
    .d_rsp_valid(d_rsp_valid), .d_rsp_addr(d_rsp_addr), .d_rsp_data(d_rsp_data),
    .i_rsp_valid(i_rsp_valid), .i_rsp_addr(i_rsp_addr), .i_rsp_data(i_rsp_data),
    .busy(busy), .protocol_error(protocol_error)
  );

  task automatic clr_inputs();
    d_req_read = 0; d_req_write = 0; d_req_addr = '0; d_req_data = '0;
    i_req_read = 0; i_req_write = 0; i_req_addr = '0; i_req_data = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_id = 0;
    mem_rsp_addr = '0; mem_rsp_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    clr_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    reset = 0; clr_inputs();
    d_req_read = 1; i_req_write = 1; mem_rsp_valid = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({d_req_ready, i_req_ready} !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready got %b exp 00", {d_req_ready, i_req_ready});
    end
    n_checks++;
    if ({mem_req_read, mem_req_write, mem_req_id} !== 3'b000) begin
      n_errors++; $display("FAIL reset_mem_ctl got %b exp 000", {mem_req_read, mem_req_write, mem_req_id});
    end
    n_checks++;
    if ({mem_req_addr, mem_req_data} !== '0) begin
      n_errors++; $display("FAIL reset_mem_payload got %h exp 0", {mem_req_addr, mem_req_data});
    end
    n_checks++;
    if ({d_rsp_valid, i_rsp_valid, busy, protocol_error} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags got %b exp 0000", {d_rsp_valid, i_rsp_valid, busy, protocol_error});
    end
    n_checks++;
    if ({d_rsp_addr, d_rsp_data, i_rsp_addr, i_rsp_data} !== '0) begin
      n_errors++; $display("FAIL reset_rsp_payload got %h exp 0", {d_rsp_addr, d_rsp_data, i_rsp_addr, i_rsp_data});
    end
    clr_inputs();
    next_cycle();
    reset = 1;
  endtask

  task automatic test_single_read();
    logic [LW-1:0] rd = rand_line();
    do_reset();
    d_req_read = 1; d_req_addr = 32'h100;
    @(negedge clock);
    n_checks++;
    if ({d_req_ready, i_req_ready, busy} !== 3'b100) begin
      n_errors++; $display("FAIL single_t0 got %b exp 100", {d_req_ready, i_req_ready, busy});
    end
    next_cycle(); d_req_read = 0; mem_req_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({mem_req_read, mem_req_write, mem_req_id, busy, mem_req_addr} !== {4'b1001, 32'h100}) begin
      n_errors++; $display("FAIL single_t1 got %h exp %h", {mem_req_read, mem_req_write, mem_req_id, busy, mem_req_addr}, {4'b1001, 32'h100});
    end
    next_cycle(); mem_req_ready = 0;
    @(negedge clock);
    n_checks++;
    if ({mem_req_read, mem_req_write} !== 2'b00) begin
      n_errors++; $display("FAIL single_drop got %b exp 00", {mem_req_read, mem_req_write});
    end
    next_cycle(); mem_rsp_valid = 1; mem_rsp_id = 0; mem_rsp_addr = 32'h100; mem_rsp_data = rd;
    @(negedge clock);
    n_checks++;
    if (d_rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_early_rsp got %b exp 0", d_rsp_valid);
    end
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, i_rsp_valid, busy, d_rsp_addr, d_rsp_data} !== {3'b100, 32'h100, rd}) begin
      n_errors++; $display("FAIL single_rsp got %h exp %h", {d_rsp_valid, i_rsp_valid, busy, d_rsp_addr, d_rsp_data}, {3'b100, 32'h100, rd});
    end
    next_cycle();
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, busy, protocol_error} !== 3'b000) begin
      n_errors++; $display("FAIL single_after got %b exp 000", {d_rsp_valid, busy, protocol_error});
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] a = $urandom();
    logic [LW-1:0] w = rand_line();
    logic [LW-1:0] x = rand_line();
    do_reset();
    d_req_write = 1; d_req_addr = a; d_req_data = w;
    @(negedge clock);
    n_checks++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      n_errors++; $display("FAIL stall_grant got %b exp 10", {d_req_ready, i_req_ready});
    end
    next_cycle(); d_req_write = 0;
    for (int k = 0; k < 6; k++) begin
      mem_req_ready = (k == 5);
      @(negedge clock);
      n_checks++;
      if ({mem_req_write, mem_req_read, mem_req_addr, mem_req_data} !== {2'b10, a, w}) begin
        n_errors++; $display("FAIL stall_hold k=%0d got %h exp %h", k, {mem_req_write, mem_req_read, mem_req_addr, mem_req_data}, {2'b10, a, w});
      end
      next_cycle();
    end
    mem_req_ready = 0;
    @(negedge clock);
    n_checks++;
    if ({mem_req_read, mem_req_write, busy} !== 3'b001) begin
      n_errors++; $display("FAIL stall_drop got %b exp 001", {mem_req_read, mem_req_write, busy});
    end
    next_cycle(); mem_rsp_valid = 1; mem_rsp_id = 0; mem_rsp_addr = a; mem_rsp_data = x;
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, d_rsp_data} !== {1'b1, x}) begin
      n_errors++; $display("FAIL stall_wr_rsp got %h exp %h", {d_rsp_valid, d_rsp_data}, {1'b1, x});
    end
  endtask

  task automatic test_wrong_id();
    logic [LW-1:0] rd = rand_line();
    do_reset();
    d_req_read = 1; d_req_addr = 32'h2000;
    next_cycle(); d_req_read = 0; mem_req_ready = 1;
    next_cycle(); mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_id = 1; mem_rsp_addr = 32'h2000; mem_rsp_data = rand_line();
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, i_rsp_valid, protocol_error, busy} !== 4'b0011) begin
      n_errors++; $display("FAIL wrongid_drop got %b exp 0011", {d_rsp_valid, i_rsp_valid, protocol_error, busy});
    end
    next_cycle(); mem_rsp_valid = 1; mem_rsp_id = 0; mem_rsp_data = rd;
    @(negedge clock);
    n_checks++;
    if ({protocol_error, busy} !== 2'b11) begin
      n_errors++; $display("FAIL wrongid_wait got %b exp 11", {protocol_error, busy});
    end
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, i_rsp_valid, protocol_error, busy, d_rsp_data} !== {4'b1010, rd}) begin
      n_errors++; $display("FAIL wrongid_done got %h exp %h", {d_rsp_valid, i_rsp_valid, protocol_error, busy, d_rsp_data}, {4'b1010, rd});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req_read = 1; d_req_addr = 32'h300;
    next_cycle(); d_req_read = 0; mem_req_ready = 1;
    next_cycle(); mem_req_ready = 0;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_busy got %b exp 1", busy);
    end
    next_cycle(); reset = 0;
    next_cycle(); reset = 1;
    @(negedge clock);
    n_checks++;
    if ({busy, protocol_error, mem_req_read} !== 3'b000) begin
      n_errors++; $display("FAIL rstmid_idle got %b exp 000", {busy, protocol_error, mem_req_read});
    end
    next_cycle();
    next_cycle(); mem_rsp_valid = 1; mem_rsp_id = 0; mem_rsp_addr = 32'h300; mem_rsp_data = rand_line();
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, i_rsp_valid, protocol_error, busy} !== 4'b0010) begin
      n_errors++; $display("FAIL rstmid_late got %b exp 0010", {d_rsp_valid, i_rsp_valid, protocol_error, busy});
    end
  endtask

  task automatic test_icache_first();
    logic [LW-1:0] w  = rand_line();
    logic [LW-1:0] rs = rand_line();
    logic [AW-1:0] b  = $urandom();
    do_reset();
    i_req_write = 1; i_req_addr = 32'h40; i_req_data = w;
    @(negedge clock);
    n_checks++;
    if ({d_req_ready, i_req_ready} !== 2'b01) begin
      n_errors++; $display("FAIL ifirst_grant got %b exp 01", {d_req_ready, i_req_ready});
    end
    next_cycle(); i_req_write = 0; d_req_read = 1; d_req_addr = b; mem_req_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({mem_req_write, mem_req_read, mem_req_id, d_req_ready, mem_req_addr, mem_req_data} !== {4'b1010, 32'h40, w}) begin
      n_errors++; $display("FAIL ifirst_issue got %h exp %h", {mem_req_write, mem_req_read, mem_req_id, d_req_ready, mem_req_addr, mem_req_data}, {4'b1010, 32'h40, w});
    end
    next_cycle(); mem_req_ready = 0;
    next_cycle(); mem_rsp_valid = 1; mem_rsp_id = 1; mem_rsp_addr = 32'h40; mem_rsp_data = rs;
    @(negedge clock);
    n_checks++;
    if (d_req_ready !== 1'b0) begin
      n_errors++; $display("FAIL ifirst_d_wait got %b exp 0", d_req_ready);
    end
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({i_rsp_valid, d_rsp_valid, d_req_ready, i_rsp_data} !== {3'b101, rs}) begin
      n_errors++; $display("FAIL ifirst_handover got %h exp %h", {i_rsp_valid, d_rsp_valid, d_req_ready, i_rsp_data}, {3'b101, rs});
    end
    next_cycle(); d_req_read = 0;
    @(negedge clock);
    n_checks++;
    if ({mem_req_read, mem_req_id, mem_req_addr} !== {2'b10, b}) begin
      n_errors++; $display("FAIL ifirst_d_issue got %h exp %h", {mem_req_read, mem_req_id, mem_req_addr}, {2'b10, b});
    end
  endtask

  task automatic test_rw_and_withdraw();
    do_reset();
    d_req_read = 1; d_req_write = 1; d_req_addr = 32'h500;
    @(negedge clock);
    n_checks++;
    if (d_req_ready !== 1'b1) begin
      n_errors++; $display("FAIL rw_grant got %b exp 1", d_req_ready);
    end
    next_cycle(); d_req_read = 0; d_req_write = 0;
    @(negedge clock);
    n_checks++;
    if ({mem_req_write, mem_req_read, protocol_error} !== 3'b101) begin
      n_errors++; $display("FAIL rw_as_write got %b exp 101", {mem_req_write, mem_req_read, protocol_error});
    end
    do_reset();
    d_req_read = 1;
    next_cycle(); d_req_read = 0; i_req_read = 1; mem_req_ready = 1;
    @(negedge clock);
    n_checks++;
    if (i_req_ready !== 1'b0) begin
      n_errors++; $display("FAIL wd_busy_ready got %b exp 0", i_req_ready);
    end
    next_cycle(); i_req_read = 0; mem_req_ready = 0;
    next_cycle(); mem_rsp_valid = 1; mem_rsp_id = 0;
    next_cycle(); mem_rsp_valid = 0;
    @(negedge clock);
    n_checks++;
    if ({d_rsp_valid, i_req_ready} !== 2'b10) begin
      n_errors++; $display("FAIL wd_rsp got %b exp 10", {d_rsp_valid, i_req_ready});
    end
    next_cycle();
    @(negedge clock);
    n_checks++;
    if ({i_req_ready, mem_req_read, mem_req_write, busy, protocol_error} !== 5'b00000) begin
      n_errors++; $display("FAIL wd_idle got %b exp 00000", {i_req_ready, mem_req_read, mem_req_write, busy, protocol_error});
    end
  endtask

  // Behavioural model: each cache holds one request until it sees ready; the
  // arbiter is free from reset and again from the cycle after a response is
  // delivered; the memory accepts on a random ready and answers later.
  task automatic run_engine(input int ncyc, input int d_pct, input int i_pct,
                            input int rw_pct, input int rdy_pct, input int max_lat);
    bit d_pend = 0, i_pend = 0, d_rd = 0, d_wr = 0, i_rd = 0, i_wr = 0;
    logic [AW-1:0] d_a = '0, i_a = '0, e_a = '0;
    logic [LW-1:0] d_dt = '0, i_dt = '0, e_dt = '0, r_dt = '0;
    logic e_rd = 0, e_wr = 0, e_id = 0;
    bit free = 1, err = 0, req_live = 0, rsp_pend = 0, rsp_now = 0, rsp_next = 0;
    bit exp_d, exp_i, iwin;
    int cnt = 0, rsp_wait = 0, k;
    grant_log.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (!d_pend && ($urandom_range(0, 99) < d_pct)) begin
        d_pend = 1; k = $urandom_range(0, 99);
        if (k < rw_pct) begin d_rd = 1; d_wr = 1; end
        else begin d_rd = k[0]; d_wr = ~k[0]; end
        d_a = $urandom(); d_dt = rand_line();
      end
      if (!i_pend && ($urandom_range(0, 99) < i_pct)) begin
        i_pend = 1; k = $urandom_range(0, 99);
        if (k < rw_pct) begin i_rd = 1; i_wr = 1; end
        else begin i_rd = k[0]; i_wr = ~k[0]; end
        i_a = $urandom(); i_dt = rand_line();
      end
      d_req_read = d_pend & d_rd; d_req_write = d_pend & d_wr; d_req_addr = d_a; d_req_data = d_dt;
      i_req_read = i_pend & i_rd; i_req_write = i_pend & i_wr; i_req_addr = i_a; i_req_data = i_dt;
      mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      mem_rsp_valid = 0; mem_rsp_id = 0; rsp_now = 0;
      if (rsp_pend) begin
        if (rsp_wait == 0) begin
          mem_rsp_valid = 1; mem_rsp_id = e_id; mem_rsp_addr = e_a; mem_rsp_data = r_dt;
          rsp_pend = 0; rsp_now = 1;
        end else begin
          rsp_wait--;
        end
      end
      @(negedge clock);
      n_checks++;
      if (req_live) begin
        if ({mem_req_read, mem_req_write, mem_req_id, mem_req_addr, mem_req_data} !== {e_rd, e_wr, e_id, e_a, e_dt}) begin
          n_errors++; $display("FAIL eng_mem_req cyc %0d got %h exp %h", c, {mem_req_read, mem_req_write, mem_req_id, mem_req_addr, mem_req_data}, {e_rd, e_wr, e_id, e_a, e_dt});
        end
        if (mem_req_ready) begin
          req_live = 0; rsp_pend = 1; rsp_wait = $urandom_range(0, max_lat); r_dt = rand_line();
        end
      end else if ({mem_req_read, mem_req_write} !== 2'b00) begin
        n_errors++; $display("FAIL eng_mem_idle cyc %0d got %b exp 00", c, {mem_req_read, mem_req_write});
      end
      n_checks++;
      if (rsp_next && !e_id) begin
        if ({d_rsp_valid, i_rsp_valid, d_rsp_addr, d_rsp_data} !== {2'b10, e_a, r_dt}) begin
          n_errors++; $display("FAIL eng_d_rsp cyc %0d got %h exp %h", c, {d_rsp_valid, i_rsp_valid, d_rsp_addr, d_rsp_data}, {2'b10, e_a, r_dt});
        end
      end else if (rsp_next && e_id) begin
        if ({d_rsp_valid, i_rsp_valid, i_rsp_addr, i_rsp_data} !== {2'b01, e_a, r_dt}) begin
          n_errors++; $display("FAIL eng_i_rsp cyc %0d got %h exp %h", c, {d_rsp_valid, i_rsp_valid, i_rsp_addr, i_rsp_data}, {2'b01, e_a, r_dt});
        end
      end else if ({d_rsp_valid, i_rsp_valid} !== 2'b00) begin
        n_errors++; $display("FAIL eng_no_rsp cyc %0d got %b exp 00", c, {d_rsp_valid, i_rsp_valid});
      end
      n_checks++;
      if ({busy, protocol_error} !== {~free, err}) begin
        n_errors++; $display("FAIL eng_flags cyc %0d got %b exp %b", c, {busy, protocol_error}, {~free, err});
      end
      exp_d = 0; exp_i = 0;
      if (free && (d_pend || i_pend)) begin
        iwin  = i_pend && (!d_pend || cnt == MW);
        exp_i = iwin; exp_d = ~iwin;
      end
      n_checks++;
      if ({d_req_ready, i_req_ready} !== {exp_d, exp_i}) begin
        n_errors++; $display("FAIL eng_ready cyc %0d got %b exp %b", c, {d_req_ready, i_req_ready}, {exp_d, exp_i});
      end
      if (exp_d || exp_i) begin
        if (exp_i) begin
          e_rd = i_rd & ~i_wr; e_wr = i_wr; e_id = 1; e_a = i_a; e_dt = i_dt;
          if (i_rd && i_wr) err = 1;
          i_pend = 0; cnt = 0;
        end else begin
          e_rd = d_rd & ~d_wr; e_wr = d_wr; e_id = 0; e_a = d_a; e_dt = d_dt;
          if (d_rd && d_wr) err = 1;
          d_pend = 0;
          if (i_pend && cnt < MW) cnt++;
        end
        grant_log.push_back(exp_i);
        req_live = 1; free = 0;
      end
      rsp_next = rsp_now;
      if (rsp_now) free = 1;
      next_cycle();
    end
    clr_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    run_engine(60, 100, 100, 0, 100, 2);
    n_checks++;
    if (grant_log.size() < 10) begin
      n_errors++; $display("FAIL starve_count got %0d grants exp >= 10", grant_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (grant_log[i] !== (i % 5 == 4)) begin
          n_errors++; $display("FAIL starve_seq idx %0d got %b exp %b", i, grant_log[i], (i % 5 == 4));
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    run_engine(1500, 40, 40, 0, 60, 3);
    do_reset();
    run_engine(1500, 90, 70, 5, 30, 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    reset = 0;
    test_reset();
    test_single_read();
    test_stall();
    test_wrong_id();
    test_reset_mid();
    test_icache_first();
    test_rw_and_withdraw();
    test_starvation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 32, physical address width; LINE_WIDTH, 128, bus data width; MAX_WAIT, 4, consecutive dcache grants tolerated while icache waits.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
 clock  in  1  single clock, rising edge
 reset  in  1  synchronous, active-low reset
 d_req_read / d_req_write  in  1 each  dcache request, level, held until d_req_ready
 d_req_addr / d_req_data  in  ADDR_WIDTH / LINE_WIDTH  dcache request payload
 i_req_read / i_req_write / i_req_addr / i_req_data  in  1/1/ADDR_WIDTH/LINE_WIDTH  icache request, same rules
 d_req_ready / i_req_ready  out  1 each  one-cycle acceptance pulse
 mem_req_read / mem_req_write  out  1 each  registered bus request
 mem_req_id  out  1  0 = dcache, 1 = icache
 mem_req_addr / mem_req_data  out  ADDR_WIDTH / LINE_WIDTH  registered payload
 mem_req_ready  in  1  memory accepts the current request
 mem_rsp_valid / mem_rsp_id / mem_rsp_addr / mem_rsp_data  in  1/1/ADDR_WIDTH/LINE_WIDTH  memory response
 d_rsp_valid / d_rsp_addr / d_rsp_data  out  1/ADDR_WIDTH/LINE_WIDTH  routed dcache response
 i_rsp_valid / i_rsp_addr / i_rsp_data  out  same widths  routed icache response
 busy  out  1  state != IDLE
 protocol_error  out  1  sticky error flag

Function
REQ-003 SHALL implement the FSM IDLE -> ISSUE -> WAIT_RSP -> IDLE, with exactly one transaction outstanding.
REQ-004 IDLE: if any request is present, SHALL pick a winner, register its read, write, addr, data and id into mem_req_*, pulse the winner's *_req_ready in the same cycle, and enter ISSUE next cycle; with no request, SHALL remain in IDLE.
REQ-005 Winner selection: dcache by default; icache wins when the starvation counter equals MAX_WAIT, or when only icache requests.
REQ-006 Starvation counter, width clog2(MAX_WAIT+1): SHALL increment on each dcache grant while i_req_read or i_req_write is high; SHALL clear on an icache grant; SHALL saturate at MAX_WAIT.
REQ-007 ISSUE: mem_req_read/write SHALL stay asserted, with payload stable, until the cycle in which mem_req_ready is high; they SHALL deassert next cycle, and the FSM SHALL enter WAIT_RSP.
REQ-008 WAIT_RSP: on mem_rsp_valid with mem_rsp_id equal to the owner id, SHALL register addr/data to the owner's *_rsp_* with *_rsp_valid high for exactly one cycle (one-cycle latency), and return to IDLE.
REQ-009 Both reads and writes complete only on a response; a write response's data SHALL be forwarded unchanged.
REQ-010 A new grant SHALL be possible no earlier than the cycle after the response is captured (IDLE cycle); minimum turnaround is 3 cycles plus memory latency.
REQ-011 mem_rsp_valid in IDLE or ISSUE, or with a non-owner id in WAIT_RSP, SHALL be dropped and SHALL set protocol_error.
REQ-012 A requester asserting read and write together SHALL be granted as a write, and SHALL set protocol_error.
REQ-013 A request deasserted before ready SHALL be treated as withdrawn; no error.
REQ-014 d_rsp_valid and i_rsp_valid SHALL never be high in the same cycle.

Reset
REQ-015 With reset low at a clock edge: state=IDLE, starvation counter=0, protocol_error=0, all *_valid/*_ready/mem_req_read/mem_req_write=0, mem_req_id=0; addr/data registers SHALL be 0.
REQ-016 Reset mid-transaction SHALL abandon the outstanding transaction; a late response SHALL be handled per REQ-011.

Structure
REQ-017 Package cpu_mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT_RSP) and the id constants DCACHE_ID=0, ICACHE_ID=1.
REQ-018 The starvation counter plus the winner picker SHALL be one sub-module, cpu_mem_arb_grant; all other logic stays in cpu_mem_arbiter.

Verification
REQ-019 dcache read 0x100 alone, mem_req_ready=1, response after 2 cycles -> d_req_ready at T0, mem_req_read/id=0 at T1, d_rsp_valid one cycle with the returned data, busy low afterward.
REQ-020 Both caches read together, MAX_WAIT=4, dcache re-requesting continuously -> grants D,D,D,D,I; counter back to 0 after the icache grant.
REQ-021 mem_req_ready held low 5 cycles in ISSUE -> request and payload stable for 6 cycles, then drop, then WAIT_RSP.
REQ-022 Response with id=1 while dcache owns -> no *_rsp_valid, protocol_error=1 and sticky, arbiter still waiting; a correct id=0 response then completes.
REQ-023 reset low during WAIT_RSP, response arrives 2 cycles after reset release -> arbiter IDLE, response dropped, protocol_error=1.
REQ-024 icache write 0x40 with d_req_read rising one cycle later -> icache finishes first, dcache granted in the next IDLE cycle.
